// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the RISC core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives
// the PC, IR, register-file and memory strobes and the datapath mux selects.
// Instruction and data accesses share one memory port through a req/ack
// handshake.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run                 leave IDLE and begin fetching (sampled only in IDLE)
//   opcode, funcode     IR fields (funcode is not interpreted here)
//   zero_flag           ALU zero result, valid in EXEC
//   mem_ack             memory access complete (may coincide with mem_req)
//   mem_req/mem_we/mem_sel_data               memory port control
//   ir_write/pc_write/pc_src                  IR / PC update
//   reg_write/reg_dst_rt/wb_sel_mem           register-file writeback
//   alu_src_imm/alu_en                        ALU operand select / capture
//   state, halted, illegal_op                 status
//   cyc_cnt, instr_cnt                        performance counters
//
// Optional feature: define MC_PERF_CNT_EN to build the cycle and retired-
// instruction counters. Without it, both counters read 0 and no counter
// flops are built.
module multicycle_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funcode,
  input  logic              zero_flag,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_sel_data,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_src,
  output logic              reg_write,
  output logic              reg_dst_rt,
  output logic              wb_sel_mem,
  output logic              alu_src_imm,
  output logic              alu_en,
  output logic [2:0]        state,
  output logic              halted,
  output logic              illegal_op,
  output logic [PERF_W-1:0] cyc_cnt,
  output logic [PERF_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q;

  // Every R-type takes the same path, so funcode is deliberately unused.
  logic unused_funcode;
  assign unused_funcode = ^funcode;

  // Opcode classes are decoded combinationally from the IR, which holds
  // the opcode stable from DECODE until the next fetch.
  logic is_r, is_imm, is_ld, is_st, is_br, is_bz, is_hlt, is_legal;
  always_comb begin
    is_r     = (opcode == 6'b000000);
    is_imm   = (opcode == 6'b001000) || (opcode == 6'b001001) ||
               (opcode[5:4] == 2'b01);
    is_ld    = (opcode == 6'b100000);
    is_st    = (opcode == 6'b100001);
    is_br    = (opcode == 6'b110000);
    is_bz    = (opcode == 6'b110001);
    is_hlt   = (opcode == 6'b111111);
    is_legal = is_r | is_imm | is_ld | is_st | is_br | is_bz | is_hlt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && !is_legal)
        illegal_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (mem_ack) state_d = S_DECODE;
      S_DECODE: state_d = is_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_r || is_imm)      state_d = S_WB;
        else if (is_ld || is_st) state_d = S_MEM;
        else if (is_hlt)         state_d = S_HALT;
        else                     state_d = S_FETCH;
      end
      S_MEM:    if (mem_ack) state_d = is_ld ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode: Moore from state_q, except the IR/PC strobes that
  // qualify on mem_ack in FETCH and on zero_flag for BZ.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    reg_dst_rt   = 1'b0;
    wb_sel_mem   = 1'b0;
    alu_src_imm  = 1'b0;
    alu_en       = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ack;
        pc_write = mem_ack;
      end
      S_EXEC: begin
        alu_en      = 1'b1;
        alu_src_imm = is_imm | is_ld | is_st;
        if (is_br) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end else if (is_bz) begin
          pc_write = zero_flag;
          pc_src   = 1'b1;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = is_st;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst_rt = ~is_r;
        wb_sel_mem = is_ld;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;

`ifdef MC_PERF_CNT_EN
  logic              retire;
  logic [PERF_W-1:0] cyc_q, instr_q;

  assign retire = (state_q == S_EXEC && (is_br || is_bz || is_hlt)) ||
                  (state_q == S_MEM && mem_ack && is_st) ||
                  (state_q == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT)
        cyc_q <= cyc_q + PERF_W'(1);
      if (retire)
        instr_q <= instr_q + PERF_W'(1);
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;
`else
  assign cyc_cnt   = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. The stimulus process drives inputs and
// queues the outputs expected in each cycle. A monitor pops and compares
// them on the falling edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, zero_flag, mem_ack;
  logic [5:0]  opcode, funcode;
  logic        mem_req, mem_we, mem_sel_data, ir_write, pc_write, pc_src;
  logic        reg_write, reg_dst_rt, wb_sel_mem, alu_src_imm, alu_en;
  logic [2:0]  state;
  logic        halted, illegal_op;
  logic [31:0] cyc_cnt, instr_cnt;

  multicycle_ctrl #(.PERF_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funcode(funcode),
    .zero_flag(zero_flag), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_sel_data(mem_sel_data), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst_rt(reg_dst_rt), .wb_sel_mem(wb_sel_mem),
    .alu_src_imm(alu_src_imm), .alu_en(alu_en), .state(state),
    .halted(halted), .illegal_op(illegal_op), .cyc_cnt(cyc_cnt),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output bit masks
  localparam logic [12:0] REQ = 13'd1,    WE  = 13'd2,    SEL = 13'd4;
  localparam logic [12:0] IRW = 13'd8,    PCW = 13'd16,   PCS = 13'd32;
  localparam logic [12:0] RW  = 13'd64,   RDT = 13'd128,  WBM = 13'd256;
  localparam logic [12:0] IMM = 13'd512,  ALU = 13'd1024, HLT = 13'd2048;
  localparam logic [12:0] ILL = 13'd4096;

  typedef struct packed {
    int          cyc;
    logic [2:0]  st;
    logic [12:0] bits;
    logic        chk;
    logic [31:0] ec;
    logic [31:0] ei;
  } exp_t;

  exp_t  sbq[$];
  string nmq[$];
  int    cyc = 0;
  int    nchk = 0;
  int    nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exc(input string nm, input logic [2:0] st, input logic [12:0] b,
                     input logic chk, input int ec, input int ei);
    exp_t e;
    e.cyc  = cyc;
    e.st   = st;
    e.bits = b;
    e.chk  = chk;
    e.ec   = ec;
    e.ei   = ei;
    sbq.push_back(e);
    nmq.push_back(nm);
  endtask

  task automatic ex(input string nm, input logic [2:0] st, input logic [12:0] b);
    exc(nm, st, b, 1'b0, 0, 0);
  endtask

  // Monitor
  exp_t        me;
  string       mn;
  logic [12:0] act;
  initial begin
    forever begin
      @(negedge clk);
      act = {illegal_op, halted, alu_en, alu_src_imm, wb_sel_mem, reg_dst_rt,
             reg_write, pc_src, pc_write, ir_write, mem_sel_data, mem_we, mem_req};
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        me = sbq.pop_front();
        mn = nmq.pop_front();
        nchk++;
        if (me.cyc != cyc) begin
          nfail++;
          $display("FAIL %s: sample for cycle %0d missed (now %0d)", mn, me.cyc, cyc);
        end else begin
          if (state !== me.st) begin
            nfail++;
            $display("FAIL %s state: got %0d expected %0d", mn, state, me.st);
          end
          nchk++;
          if (act !== me.bits) begin
            nfail++;
            $display("FAIL %s strobes: got %013b expected %013b", mn, act, me.bits);
          end
          if (me.chk) begin
            nchk++;
            if (cyc_cnt !== me.ec) begin
              nfail++;
              $display("FAIL %s cyc_cnt: got %0d expected %0d", mn, cyc_cnt, me.ec);
            end
            nchk++;
            if (instr_cnt !== me.ei) begin
              nfail++;
              $display("FAIL %s instr_cnt: got %0d expected %0d", mn, instr_cnt, me.ei);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [5:0] imm_ops [2] = '{6'b001001, 6'b011010};

  initial begin
    rst = 1'b1; run = 1'b0; opcode = '0; funcode = 6'h2a;
    zero_flag = 1'b0; mem_ack = 1'b1;
    tick;
    exc("reset", 3'd0, '0, 1'b1, 0, 0);
    rst = 1'b0; run = 1'b1;
    tick;

    // Three R-type instructions, then HLT, with zero-wait memory
    for (int i = 0; i < 3; i++) begin
      opcode = 6'b000000;
      ex("r_fetch", 3'd1, REQ | IRW | PCW); tick;
      ex("r_dec",   3'd2, '0);              tick;
      ex("r_exec",  3'd3, ALU);             tick;
      ex("r_wb",    3'd5, RW);              tick;
    end
    opcode = 6'b111111;
    ex("hlt_fetch", 3'd1, REQ | IRW | PCW); tick;
    ex("hlt_dec",   3'd2, '0);              tick;
    ex("hlt_exec",  3'd3, ALU);             tick;
    run = 1'b0;
    exc("perf_halt", 3'd6, HLT, 1'b1, PERF ? 15 : 0, PERF ? 4 : 0); tick;
    run = 1'b1;
    ex("halt_run", 3'd6, HLT); tick;
    rst = 1'b1;
    ex("halt_rst_cyc", 3'd6, HLT); tick;
    rst = 1'b0;
    exc("halt_rst", 3'd0, '0, 1'b1, 0, 0); tick;

    // LD with three ack wait cycles in MEM
    opcode = 6'b100000;
    ex("ld_fetch", 3'd1, REQ | IRW | PCW); tick;
    ex("ld_dec",   3'd2, '0);              tick;
    ex("ld_exec",  3'd3, ALU | IMM);       tick;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex("ld_memwait", 3'd4, REQ | SEL); tick;
    end
    mem_ack = 1'b1;
    ex("ld_memack", 3'd4, REQ | SEL);        tick;
    ex("ld_wb",     3'd5, RW | RDT | WBM);   tick;

    // ST with one ack wait cycle in FETCH
    opcode = 6'b100001;
    mem_ack = 1'b0;
    ex("st_fwait", 3'd1, REQ);               tick;
    mem_ack = 1'b1;
    ex("st_fetch", 3'd1, REQ | IRW | PCW);   tick;
    ex("st_dec",   3'd2, '0);                tick;
    ex("st_exec",  3'd3, ALU | IMM);         tick;
    ex("st_mem",   3'd4, REQ | SEL | WE);    tick;

    // Immediate forms
    for (int i = 0; i < 2; i++) begin
      opcode = imm_ops[i];
      ex("imm_fetch", 3'd1, REQ | IRW | PCW); tick;
      ex("imm_dec",   3'd2, '0);              tick;
      ex("imm_exec",  3'd3, ALU | IMM);       tick;
      ex("imm_wb",    3'd5, RW | RDT);        tick;
    end

    // BR, then BZ taken and not taken
    opcode = 6'b110000;
    ex("br_fetch", 3'd1, REQ | IRW | PCW); tick;
    ex("br_dec",   3'd2, '0);              tick;
    ex("br_exec",  3'd3, ALU | PCW | PCS); tick;
    opcode = 6'b110001;
    zero_flag = 1'b1;
    ex("bz1_fetch", 3'd1, REQ | IRW | PCW); tick;
    ex("bz1_dec",   3'd2, '0);              tick;
    ex("bz1_exec",  3'd3, ALU | PCW | PCS); tick;
    zero_flag = 1'b0;
    ex("bz0_fetch", 3'd1, REQ | IRW | PCW); tick;
    ex("bz0_dec",   3'd2, '0);              tick;
    ex("bz0_exec",  3'd3, ALU | PCS);       tick;

    // Reset while MEM waits for ack
    opcode = 6'b100000;
    ex("ldr_fetch", 3'd1, REQ | IRW | PCW); tick;
    ex("ldr_dec",   3'd2, '0);              tick;
    ex("ldr_exec",  3'd3, ALU | IMM);       tick;
    mem_ack = 1'b0;
    ex("ldr_wait",  3'd4, REQ | SEL);       tick;
    rst = 1'b1;
    ex("ldr_rst_cyc", 3'd4, REQ | SEL);     tick;
    rst = 1'b0;
    mem_ack = 1'b1;
    exc("ldr_after_rst", 3'd0, '0, 1'b1, 0, 0); tick;

    // Undefined opcode
    opcode = 6'b000101;
    ex("ill_fetch", 3'd1, REQ | IRW | PCW); tick;
    ex("ill_dec",   3'd2, '0);              tick;
    ex("ill_halt",  3'd6, HLT | ILL);       tick;
    run = 1'b0;
    ex("ill_run0",  3'd6, HLT | ILL);       tick;
    run = 1'b1;
    ex("ill_run1",  3'd6, HLT | ILL);       tick;
    rst = 1'b1;
    ex("ill_rst_cyc", 3'd6, HLT | ILL);     tick;
    rst = 1'b0;
    run = 1'b0;
    ex("ill_rst",   3'd0, '0);              tick;
    ex("idle_hold", 3'd0, '0);              tick;

    tick;
    tick;
    if (sbq.size() != 0) begin
      nchk++;
      nfail++;
      $display("FAIL drain: %0d expected samples never compared, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RISC core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives PC/IR/register-file/memory strobes and datapath muxes.
- Sits beside the ALU control decoder: both see the same opcode/funcode. This block asserts alu_en only in the cycles where the ALU result is consumed.
- Shares one memory port between instruction and data accesses via a req/ack handshake.

Parameters:
PERF_W, 32, width of performance counters (only used with MC_PERF_CNT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
run  in  1  leave IDLE and begin fetching
opcode  in  6  IR[31:26], valid from DECODE onward
funcode  in  6  IR[5:0], R-type function
zero_flag  in  1  ALU zero result, valid in EXEC
mem_ack  in  1  memory access complete; may be high in the same cycle as mem_req
mem_req  out  1  memory access request
mem_we  out  1  write request (store)
mem_sel_data  out  1  0 = address from PC, 1 = address from ALU result
ir_write  out  1  load IR from memory read data
pc_write  out  1  update PC
pc_src  out  1  0 = PC+1, 1 = branch target
reg_write  out  1  register-file write enable
reg_dst_rt  out  1  1 = destination is rt (immediate/load), 0 = rd
wb_sel_mem  out  1  1 = write back memory data, 0 = ALU result
alu_src_imm  out  1  1 = ALU operand B is the immediate
alu_en  out  1  ALU result register capture enable
state  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6
halted  out  1  in HALT
illegal_op  out  1  sticky flag: HALT was entered via an undefined opcode
cyc_cnt  out  PERF_W  cycles since leaving IDLE
instr_cnt  out  PERF_W  instructions retired

Behaviour:
- Reset: synchronous; state=IDLE, illegal_op=0, counters=0, all strobes/mux selects 0. rst wins over every other input in the same cycle, including mid-access: an outstanding mem_req is dropped with no retry.
- Outputs are Moore-decoded from the state register. Exception: ir_write, pc_write and instr_cnt increments qualify on mem_ack/state as noted below.
- IDLE: all strobes 0. run=1 -> FETCH.
- FETCH: mem_req=1, mem_sel_data=0. Hold while mem_ack=0. When mem_ack=1: ir_write=1, pc_write=1, pc_src=0, then -> DECODE.
- DECODE: one cycle, no strobes. Opcode classes:
  - R-type: opcode==000000.
  - Immediate: opcode==001000, 001001, or opcode[5:4]==01.
  - LD: 100000. ST: 100001. BR: 110000. BZ: 110001. HLT: 111111.
  - Any other opcode -> HALT with illegal_op=1; otherwise -> EXEC.
- EXEC: one cycle; alu_en=1 for all classes.
  - alu_src_imm=1 for Immediate/LD/ST.
  - R-type/Immediate -> WB. LD/ST -> MEM.
  - BR: pc_write=1, pc_src=1, retire, -> FETCH.
  - BZ: pc_write=zero_flag, pc_src=1, retire, -> FETCH.
  - HLT: retire, -> HALT.
- MEM: mem_req=1, mem_sel_data=1, mem_we=(ST). Hold while mem_ack=0. On ack: LD -> WB; ST retires -> FETCH.
- WB: reg_write=1, reg_dst_rt=(class!=R-type), wb_sel_mem=(LD), retire, -> FETCH.
- HALT: all strobes 0, halted=1. Exits only via rst. run is ignored.
- Latency with zero-wait memory (ack in the same cycle as req): R/Imm 4 cycles, LD 5, ST 4, BR/BZ 3. Each extra ack wait cycle adds 1.
- funcode is not interpreted here. Every R-type takes the same 4-cycle path.
- run deasserting mid-instruction has no effect. It is only sampled in IDLE.

Optional Feature:
- MC_PERF_CNT_EN defined:
  - cyc_cnt increments every cycle while state is not IDLE and not HALT.
  - instr_cnt increments on every retire event: EXEC for BR/BZ/HLT, MEM ack for ST, WB for all others.
  - Both counters wrap modulo 2^PERF_W and clear on rst.
- MC_PERF_CNT_EN undefined: cyc_cnt and instr_cnt are tied to 0 and no counter flops are built.

Test Plan:
- rst, run=1, mem_ack tied 1, opcode=000000 -> states 1,2,3,5,1; reg_write=1 only in WB with reg_dst_rt=0; 4 cycles per instruction.
- LD (100000) with mem_ack delayed 3 cycles in MEM -> mem_req=1, mem_sel_data=1, mem_we=0 held for 4 cycles; then WB with wb_sel_mem=1, reg_dst_rt=1; total 8 cycles.
- BZ (110001) with zero_flag=1, then again with zero_flag=0 -> pc_write=1, pc_src=1 in EXEC for the first; pc_write=0 in EXEC for the second; each 3 cycles.
- Undefined opcode 000101 -> DECODE -> HALT; halted=1, illegal_op=1; run toggling keeps HALT; rst returns state=0 and illegal_op=0.
- rst asserted in MEM while waiting for mem_ack=0 -> next cycle state=0 and mem_req=0.
- With MC_PERF_CNT_EN: 3 R-type + HLT, zero-wait -> instr_cnt=4, cyc_cnt=15; without the macro both read 0.
